// File: rtl/tachyon_fetch_arbiter_if.sv
// Bundle of fetch-port, RAM-port and status signals shared by the fetch arbiter.
// It also carries the round-robin pointer as a debug observation point.
interface tachyon_fetch_arbiter_if #(
    parameter int NR_PORTS   = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int PTR_W = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;

    // Handshake: a port's request is taken in the cycle its req_gnt bit is high.
    // The requester holds req_en/req_addr until that cycle. rsp_valid then pulses
    // for exactly one cycle, RAM_LAT cycles later. There is no response backpressure.
    logic [NR_PORTS-1:0]                  req_en;
    logic [NR_PORTS*(ADDR_WIDTH-2)-1:0]   req_addr;
    logic [NR_PORTS-1:0]                  port_mask;
    logic [NR_PORTS-1:0]                  req_gnt;
    logic [NR_PORTS-1:0]                  rsp_valid;
    logic [DATA_WIDTH-1:0]                rsp_data;
    logic                                 ram_rd_en;
    logic [ADDR_WIDTH-3:0]                ram_rd_addr;
    logic [DATA_WIDTH-1:0]                ram_rd_data;
    logic                                 busy;
    logic [PTR_W-1:0]                     dbg_rr_ptr;

    modport master (
        output req_en, req_addr, port_mask, ram_rd_data,
        input  req_gnt, rsp_valid, rsp_data, ram_rd_en, ram_rd_addr, busy, dbg_rr_ptr
    );

    modport slave (
        input  req_en, req_addr, port_mask, ram_rd_data,
        output req_gnt, rsp_valid, rsp_data, ram_rd_en, ram_rd_addr, busy, dbg_rr_ptr
    );
endinterface

// File: rtl/tachyon_fetch_arbiter.sv
// Round-robin arbiter sharing one synchronous-read RAM port between NR_PORTS fetch ports.
// Each response is routed back by a one-hot grant pipeline that matches the RAM latency.
module tachyon_fetch_arbiter #(
    parameter int NR_PORTS   = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int RAM_LAT    = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    tachyon_fetch_arbiter_if.slave bus
);
    localparam int WA    = ADDR_WIDTH - 2;
    localparam int PTR_W = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;

    logic [NR_PORTS-1:0]   eligible;
    logic [NR_PORTS-1:0]   gnt;
    logic [PTR_W-1:0]      gnt_idx;
    logic [PTR_W-1:0]      scan_idx;
    logic [PTR_W-1:0]      rr_ptr;
    logic                  found;
    logic [WA-1:0]         ram_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  in_flight;
    logic [NR_PORTS-1:0]   rsp_pipe [RAM_LAT];

    assign eligible = bus.req_en & ~bus.port_mask;

    // Scan from rr_ptr upward with wrap. Grants are suppressed while reset is held.
    always_comb begin
        gnt      = '0;
        gnt_idx  = '0;
        scan_idx = '0;
        found    = 1'b0;
        for (int o = 0; o < NR_PORTS; o++) begin
            scan_idx = PTR_W'((int'(rr_ptr) + o) % NR_PORTS);
            if (!found && !rst && eligible[scan_idx]) begin
                gnt[scan_idx] = 1'b1;
                gnt_idx       = scan_idx;
                found         = 1'b1;
            end
        end
    end

    always_comb begin
        ram_addr = '0;
        for (int i = 0; i < NR_PORTS; i++) begin
            if (gnt[i]) ram_addr = bus.req_addr[i*WA +: WA];
        end
    end

    generate
        if (NR_PORTS > 1) begin : g_ptr
            always_ff @(posedge clk or posedge rst) begin
                if (rst)        rr_ptr <= '0;
                else if (found) rr_ptr <= (gnt_idx == PTR_W'(NR_PORTS - 1)) ? '0
                                                                             : gnt_idx + PTR_W'(1);
            end
        end else begin : g_no_ptr
            assign rr_ptr = '0;
        end
    endgenerate

    // Each stage carries the one-hot owner of the RAM read issued that many cycles ago.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < RAM_LAT; j++) rsp_pipe[j] <= '0;
        end else begin
            rsp_pipe[0] <= gnt;
            for (int j = 1; j < RAM_LAT; j++) rsp_pipe[j] <= rsp_pipe[j-1];
        end
    end

    always_comb begin
        in_flight = 1'b0;
        for (int j = 0; j < RAM_LAT; j++) in_flight = in_flight | (|rsp_pipe[j]);
    end

    assign rd_data         = bus.ram_rd_data;
    assign bus.req_gnt     = gnt;
    assign bus.ram_rd_en   = |gnt;
    assign bus.ram_rd_addr = ram_addr;
    assign bus.rsp_valid   = rsp_pipe[RAM_LAT-1];
    assign bus.rsp_data    = rd_data;
    assign bus.busy        = in_flight;
    assign bus.dbg_rr_ptr  = rr_ptr;
endmodule
